// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory fetch block: FSM encoding,
// fault codes and the boot program image.
package imem_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] fault_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_RESP = 2'd2;

  localparam fault_t FAULT_OK       = 2'b00;
  localparam fault_t FAULT_MISALIGN = 2'b01;
  localparam fault_t FAULT_RANGE    = 2'b10;

  localparam int BOOT_WORDS = 6;

  function automatic logic [31:0] boot_word(input int idx);
    case (idx)
      1:       return 32'h3402_0026;
      2:       return 32'h3403_0034;
      3:       return 32'h0062_8020;
      4:       return 32'hAE02_0001;
      5:       return 32'h8E03_0001;
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/imem_array.sv
// Byte-organised little-endian instruction store: one synchronous read port,
// one write port, contents optionally preloaded and never touched by reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter bit INIT_EN     = 1'b1,
  localparam int AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  function automatic logic [DEPTH_WORDS*32-1:0] boot_image();
    logic [DEPTH_WORDS*32-1:0] img;
    img = '0;
    if (INIT_EN) begin
      for (int w = 0; w < BOOT_WORDS && w < DEPTH_WORDS; w++) begin
        img[w*32 +: 32] = boot_word(w);
      end
    end
    return img;
  endfunction

  // Byte at address A lives at bits A*8 +: 8, so word w bits 7:0 hold byte 4w.
  logic [DEPTH_WORDS*32-1:0] mem_q = boot_image();
  logic [DEPTH_WORDS*32-1:0] mem_d;
  logic [31:0]               rdata_q;
  logic [31:0]               rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        mem_d[{waddr, 2'(b), 3'b000} +: 8] = wdata[b*8 +: 8];
      end
    end
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem_q[{raddr, 5'b00000} +: 32];
    end
  end

  always_ff @(posedge clk) begin
    mem_q   <= mem_d;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch port with optional wait states, fault reporting and a
// program-load write port sharing the same byte-organised store.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 32,
  parameter int WAIT_CYCLES = 0,
  parameter bit INIT_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] addr,
  output logic        ready,
  output logic [31:0] out,
  output logic        valid,
  output logic [1:0]  fault,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] LIMIT   = 32'(4 * DEPTH_WORDS);
  localparam logic [2:0]  WAIT_LD = 3'(WAIT_CYCLES);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  fault_t      pend_fault_q, pend_fault_d;
  logic [31:0] hold_out_q, hold_out_d;
  fault_t      hold_fault_q, hold_fault_d;

  logic        accept;
  fault_t      req_fault;
  logic        ld_ok;
  logic [31:0] rd_word;

  imem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_EN     (INIT_EN)
  ) u_array (
    .clk   (clk),
    .we    (ld_ok),
    .waddr (ld_addr[AW+1:2]),
    .wdata (ld_data),
    .re    (accept),
    .raddr (addr[AW+1:2]),
    .rdata (rd_word)
  );

  always_comb begin
    ld_ok = ld_en && (ld_addr[1:0] == 2'b00) && (ld_addr < LIMIT);

    ready  = (state_q != ST_WAIT);
    accept = req && ready;
    if (addr[1:0] != 2'b00) begin
      req_fault = FAULT_MISALIGN;
    end else if (addr >= LIMIT) begin
      req_fault = FAULT_RANGE;
    end else begin
      req_fault = FAULT_OK;
    end

    // The read port captured the word at the accept edge; outputs follow it
    // only while in RESP and otherwise replay the last response.
    valid = (state_q == ST_RESP);
    if (valid) begin
      out   = (pend_fault_q == FAULT_OK) ? rd_word : 32'h0;
      fault = pend_fault_q;
    end else begin
      out   = hold_out_q;
      fault = hold_fault_q;
    end
    hold_out_d   = out;
    hold_fault_d = fault;

    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_fault_d = pend_fault_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q <= 3'd1) begin
          state_d = ST_RESP;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        if (accept) begin
          pend_fault_d = req_fault;
          if (WAIT_LD == 3'd0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_LD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      pend_fault_q <= FAULT_OK;
      hold_out_q   <= 32'h0;
      hold_fault_q <= FAULT_OK;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_fault_q <= pend_fault_d;
      hold_out_q   <= hold_out_d;
      hold_fault_q <= hold_fault_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: one instance with no wait states and one
// with two wait states, sharing clock and reset.
module tb_imem_fetch;

  logic        clk;
  logic        rst;

  logic        req0, ld_en0, ready0, valid0;
  logic [31:0] addr0, ld_addr0, ld_data0, out0;
  logic [1:0]  fault0;

  logic        req2, ld_en2, ready2, valid2;
  logic [31:0] addr2, ld_addr2, ld_data2, out2;
  logic [1:0]  fault2;

  int checks = 0;
  int errors = 0;

  imem_fetch #(.DEPTH_WORDS(32), .WAIT_CYCLES(0), .INIT_EN(1'b1)) u_dut0 (
    .clk(clk), .rst(rst), .req(req0), .addr(addr0), .ready(ready0),
    .out(out0), .valid(valid0), .fault(fault0),
    .ld_en(ld_en0), .ld_addr(ld_addr0), .ld_data(ld_data0)
  );

  imem_fetch #(.DEPTH_WORDS(32), .WAIT_CYCLES(2), .INIT_EN(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .req(req2), .addr(addr2), .ready(ready2),
    .out(out2), .valid(valid2), .fault(fault2),
    .ld_en(ld_en2), .ld_addr(ld_addr2), .ld_data(ld_data2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic do_load(input int inst, input logic [31:0] a, input logic [31:0] d);
    if (inst == 0) begin ld_en0 = 1'b1; ld_addr0 = a; ld_data0 = d; end
    else           begin ld_en2 = 1'b1; ld_addr2 = a; ld_data2 = d; end
    @(posedge clk); #1;
    ld_en0 = 1'b0;
    ld_en2 = 1'b0;
  endtask

  // lat counts cycles from the accept edge to the valid sample (0 = never seen).
  task automatic do_fetch(input int inst, input logic [31:0] a,
                          output logic [31:0] o, output logic [1:0] f, output int lat);
    if (inst == 0) begin req0 = 1'b1; addr0 = a; end
    else           begin req2 = 1'b1; addr2 = a; end
    @(posedge clk); #1;
    req0 = 1'b0;
    req2 = 1'b0;
    lat = 0;
    o = 32'h0;
    f = 2'b00;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if ((inst == 0) ? valid0 : valid2) begin
        lat = i;
        o = (inst == 0) ? out0 : out2;
        f = (inst == 0) ? fault0 : fault2;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] o;
  logic [1:0]  f;
  int          lat;
  logic        saw;
  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_exp  [4];

  initial begin
    b2b_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
    b2b_exp  = '{32'h0000_0000, 32'h3402_0026, 32'h3403_0034, 32'h0062_8020};
    rst = 1'b1;
    req0 = 1'b0; addr0 = '0; ld_en0 = 1'b0; ld_addr0 = '0; ld_data0 = '0;
    req2 = 1'b0; addr2 = '0; ld_en2 = 1'b0; ld_addr2 = '0; ld_data2 = '0;

    #12;
    chk("rst_valid", valid2, 1'b0);
    chk("rst_out", out2, 32'h0);
    chk("rst_fault", fault2, 2'b00);
    chk("rst_valid0", valid0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready2", ready2, 1'b1);
    chk("rst_ready0", ready0, 1'b1);
    @(posedge clk); #1;

    // Two wait states: ready low two cycles, valid on the third.
    req2 = 1'b1; addr2 = 32'h4;
    @(negedge clk);
    chk("w2_ready_idle", ready2, 1'b1);
    @(posedge clk); #1;
    req2 = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("w2_ready_wait", ready2, 1'b0);
      chk("w2_no_valid", valid2, 1'b0);
    end
    @(negedge clk);
    chk("w2_valid", valid2, 1'b1);
    chk("w2_out", out2, 32'h3402_0026);
    chk("w2_fault", fault2, 2'b00);
    chk("w2_ready_resp", ready2, 1'b1);
    @(negedge clk);
    chk("w2_valid_pulse", valid2, 1'b0);
    chk("w2_out_hold", out2, 32'h3402_0026);
    @(posedge clk); #1;
    do_fetch(2, 32'h8, o, f, lat);
    chk("w2_lat", lat, 3);
    chk("w2_out8", o, 32'h3403_0034);

    // No wait states, back-to-back requests.
    req0 = 1'b1; addr0 = b2b_addr[0];
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) addr0 = b2b_addr[i+1];
      else       req0 = 1'b0;
      @(negedge clk);
      chk("b2b_valid", valid0, 1'b1);
      chk("b2b_out", out0, b2b_exp[i]);
      chk("b2b_ready", ready0, 1'b1);
    end
    @(negedge clk);
    chk("b2b_end", valid0, 1'b0);
    chk("b2b_hold", out0, 32'h0062_8020);
    @(posedge clk); #1;

    // Fault reporting and range boundary.
    do_fetch(0, 32'h6, o, f, lat);
    chk("mis_lat", lat, 1);
    chk("mis_fault", f, 2'b01);
    chk("mis_out", o, 32'h0);
    do_fetch(0, 32'h80, o, f, lat);
    chk("rng_fault", f, 2'b10);
    chk("rng_out", o, 32'h0);
    do_fetch(0, 32'h81, o, f, lat);
    chk("prio_fault", f, 2'b01);
    do_fetch(0, 32'h7C, o, f, lat);
    chk("last_fault", f, 2'b00);
    do_fetch(0, 32'h10, o, f, lat);
    chk("w4_out", o, 32'hAE02_0001);

    // Program load, then same-edge load and fetch.
    do_load(0, 32'h8, 32'h1234_5678);
    do_fetch(0, 32'h8, o, f, lat);
    chk("ld_out", o, 32'h1234_5678);
    ld_en0 = 1'b1; ld_addr0 = 32'hC; ld_data0 = 32'hDEAD_BEEF;
    req0 = 1'b1; addr0 = 32'hC;
    @(posedge clk); #1;
    ld_en0 = 1'b0; req0 = 1'b0;
    @(negedge clk);
    chk("same_valid", valid0, 1'b1);
    chk("same_old", out0, 32'h0062_8020);
    @(posedge clk); #1;
    do_fetch(0, 32'hC, o, f, lat);
    chk("same_new", o, 32'hDEAD_BEEF);

    // Illegal loads leave memory untouched.
    do_load(0, 32'h12, 32'hFFFF_FFFF);
    do_load(0, 32'h80, 32'hBAD0_BAD0);
    do_fetch(0, 32'h10, o, f, lat);
    chk("badld_w4", o, 32'hAE02_0001);
    do_fetch(0, 32'h14, o, f, lat);
    chk("badld_w5", o, 32'h8E03_0001);
    do_fetch(0, 32'h0, o, f, lat);
    chk("badld_w0", o, 32'h0);

    // Reset while waiting aborts the fetch and preserves memory.
    do_load(2, 32'h14, 32'hCAFE_F00D);
    req2 = 1'b1; addr2 = 32'h14;
    @(posedge clk); #1;
    req2 = 1'b0;
    @(negedge clk);
    chk("abort_in_wait", ready2, 1'b0);
    rst = 1'b1;
    #1;
    chk("abort_valid", valid2, 1'b0);
    chk("abort_out", out2, 32'h0);
    chk("abort_ready", ready2, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (valid2) saw = 1'b1;
    end
    chk("abort_no_valid", saw, 1'b0);
    chk("abort_fault", fault2, 2'b00);
    @(posedge clk); #1;
    do_fetch(2, 32'h10, o, f, lat);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_w4", o, 32'hAE02_0001);
    do_fetch(2, 32'h14, o, f, lat);
    chk("post_rst_ld", o, 32'hCAFE_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
